// File: rtl/ifm_addr_pkg.sv
// Shared types and constants for the IFM read-address generator.
package ifm_addr_pkg;

  // Layer-walk controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Legal kernel and stride encodings
  localparam logic [1:0] K_ONE   = 2'd1;
  localparam logic [1:0] K_THREE = 2'd3;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  // Width of the tile_size field (holds 1..16)
  localparam int TILE_W = 5;

  // Number of valid output columns in a tile: min(array width, columns remaining)
  function automatic logic [TILE_W-1:0] clamp_tile(input logic [15:0] remaining,
                                                    input logic [15:0] sys);
    logic [15:0] r;
    r = (remaining < sys) ? remaining : sys;
    return r[TILE_W-1:0];
  endfunction

endpackage

// File: rtl/ifm_win_counter.sv
// Nested kx / ky / channel counter for one convolution window.
// Wrap flags are combinational from the current counts; a full wrap
// (kx, ky and c all at their maximum) returns every count to zero.
module ifm_win_counter
  import ifm_addr_pkg::*;
#(
  parameter int CH_WIDTH = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                advance,
  input  logic [1:0]          k_max,
  input  logic [CH_WIDTH-1:0] c_max,
  output logic                kx_wrap,
  output logic                ky_wrap,
  output logic                c_wrap
);

  logic [1:0]          kx_q, kx_d;
  logic [1:0]          ky_q, ky_d;
  logic [CH_WIDTH-1:0] c_q, c_d;

  assign kx_wrap = (kx_q == k_max);
  assign ky_wrap = (ky_q == k_max);
  assign c_wrap  = (c_q == c_max);

  // Next count: kx fastest, then ky, then channel
  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    c_d  = c_q;
    if (clear) begin
      kx_d = '0;
      ky_d = '0;
      c_d  = '0;
    end else if (advance) begin
      if (!kx_wrap) begin
        kx_d = kx_q + 2'd1;
      end else begin
        kx_d = '0;
        if (!ky_wrap) begin
          ky_d = ky_q + 2'd1;
        end else begin
          ky_d = '0;
          c_d  = c_wrap ? '0 : c_q + CH_WIDTH'(1);
        end
      end
    end
  end

  // Count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_q <= '0;
      ky_q <= '0;
      c_q  <= '0;
    end else begin
      kx_q <= kx_d;
      ky_q <= ky_d;
      c_q  <= c_d;
    end
  end

endmodule

// File: rtl/ifm_addr_gen.sv
// Run-time configurable IFM read-address generator. Walks a full layer
// strip by strip (SYSTOLIC_SIZE output columns), row by row inside a strip,
// and streams C*K*K window addresses per tile over valid/ready.
// After the single setup cycle every address is produced by additions only.
module ifm_addr_gen
  import ifm_addr_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int ADDR_WIDTH    = 20,
  parameter int DIM_WIDTH     = 10,
  parameter int CH_WIDTH      = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [DIM_WIDTH-1:0]  cfg_ifm_size,
  input  logic [CH_WIDTH-1:0]   cfg_channel,
  input  logic [1:0]            cfg_kernel,
  input  logic [1:0]            cfg_stride,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] ifm_addr,
  output logic [TILE_W-1:0]     tile_size,
  output logic                  tile_last,
  output logic                  busy,
  output logic                  done
);

  localparam int COL_W = DIM_WIDTH + 1;

  state_e                state_q, state_d;

  // Layer configuration captured on start
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DIM_WIDTH-1:0]  w_q, w_d;
  logic [1:0]            k_q, k_d;
  logic [1:0]            s_q, s_d;
  logic [CH_WIDTH-1:0]   c_q, c_d;

  // Constants derived once in SETUP
  logic [DIM_WIDTH-1:0]  ofm_q, ofm_d;
  logic [ADDR_WIDTH-1:0] plane_q, plane_d;
  logic [ADDR_WIDTH-1:0] row_step_q, row_step_d;
  logic [ADDR_WIDTH-1:0] strip_step_q, strip_step_d;

  // Running pointers: strip origin, output-row origin, channel origin, kernel line, address
  logic [ADDR_WIDTH-1:0] strip_ptr_q, strip_ptr_d;
  logic [ADDR_WIDTH-1:0] row_ptr_q, row_ptr_d;
  logic [ADDR_WIDTH-1:0] chan_q, chan_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Tile position
  logic [DIM_WIDTH-1:0]  row_q, row_d;
  logic [COL_W-1:0]      col0_q, col0_d;
  logic [TILE_W-1:0]     tile_size_q, tile_size_d;

  // Combinational helpers
  logic [DIM_WIDTH-1:0]  span;
  logic [DIM_WIDTH-1:0]  ofm_calc;
  logic [ADDR_WIDTH-1:0] w_ext;
  logic [ADDR_WIDTH-1:0] next_line, next_chan, next_row, next_strip;
  logic [COL_W-1:0]      col0_next;
  logic                  last_row, more_strips;
  logic                  accept, cnt_clear;
  logic                  kx_wrap, ky_wrap, c_wrap;
  logic [1:0]            k_max;
  logic [CH_WIDTH-1:0]   c_max;

  assign w_ext       = ADDR_WIDTH'(w_q);
  assign span        = (k_q == K_ONE) ? (w_q - DIM_WIDTH'(1)) : (w_q - DIM_WIDTH'(3));
  assign ofm_calc    = ((s_q == S_TWO) ? (span >> 1) : span) + DIM_WIDTH'(1);
  assign next_line   = line_q + w_ext;
  assign next_chan   = chan_q + plane_q;
  assign next_row    = row_ptr_q + row_step_q;
  assign next_strip  = strip_ptr_q + strip_step_q;
  assign col0_next   = col0_q + COL_W'(SYSTOLIC_SIZE);
  assign last_row    = (row_q == (ofm_q - DIM_WIDTH'(1)));
  assign more_strips = (col0_next < COL_W'(ofm_q));
  assign accept      = (state_q == ST_RUN) && addr_ready;
  assign k_max       = (k_q == K_THREE) ? 2'd2 : 2'd0;
  assign c_max       = c_q - CH_WIDTH'(1);

  ifm_win_counter #(
    .CH_WIDTH (CH_WIDTH)
  ) u_win_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .advance (accept),
    .k_max   (k_max),
    .c_max   (c_max),
    .kx_wrap (kx_wrap),
    .ky_wrap (ky_wrap),
    .c_wrap  (c_wrap)
  );

  assign addr_valid = (state_q == ST_RUN);
  assign ifm_addr   = addr_q;
  assign tile_size  = tile_size_q;
  assign tile_last  = (state_q == ST_RUN) && kx_wrap && ky_wrap && c_wrap;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

  // Next-state, config capture, setup derivation and pointer stepping
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    w_d          = w_q;
    k_d          = k_q;
    s_d          = s_q;
    c_d          = c_q;
    ofm_d        = ofm_q;
    plane_d      = plane_q;
    row_step_d   = row_step_q;
    strip_step_d = strip_step_q;
    strip_ptr_d  = strip_ptr_q;
    row_ptr_d    = row_ptr_q;
    chan_d       = chan_q;
    line_d       = line_q;
    addr_d       = addr_q;
    row_d        = row_q;
    col0_d       = col0_q;
    tile_size_d  = tile_size_q;
    cnt_clear    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          base_d    = cfg_base;
          w_d       = cfg_ifm_size;
          k_d       = cfg_kernel;
          s_d       = cfg_stride;
          c_d       = cfg_channel;
          cnt_clear = 1'b1;
        end
      end

      ST_SETUP: begin
        // The only multiply in the block: channel plane size
        ofm_d        = ofm_calc;
        plane_d      = w_ext * w_ext;
        row_step_d   = (s_q == S_ONE) ? w_ext : (w_ext << 1);
        strip_step_d = (s_q == S_ONE) ? ADDR_WIDTH'(SYSTOLIC_SIZE)
                                      : ADDR_WIDTH'(SYSTOLIC_SIZE * 2);
        strip_ptr_d  = base_q;
        row_ptr_d    = base_q;
        chan_d       = base_q;
        line_d       = base_q;
        addr_d       = base_q;
        row_d        = '0;
        col0_d       = '0;
        tile_size_d  = clamp_tile(16'(ofm_calc), 16'(SYSTOLIC_SIZE));
        state_d      = ST_RUN;
      end

      ST_RUN: begin
        if (addr_ready) begin
          if (!kx_wrap) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end else if (!ky_wrap) begin
            line_d = next_line;
            addr_d = next_line;
          end else if (!c_wrap) begin
            chan_d = next_chan;
            line_d = next_chan;
            addr_d = next_chan;
          end else if (!last_row) begin
            row_d     = row_q + DIM_WIDTH'(1);
            row_ptr_d = next_row;
            chan_d    = next_row;
            line_d    = next_row;
            addr_d    = next_row;
          end else if (more_strips) begin
            row_d       = '0;
            col0_d      = col0_next;
            strip_ptr_d = next_strip;
            row_ptr_d   = next_strip;
            chan_d      = next_strip;
            line_d      = next_strip;
            addr_d      = next_strip;
            tile_size_d = clamp_tile(16'(COL_W'(ofm_q) - col0_next), 16'(SYSTOLIC_SIZE));
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, configuration and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      w_q          <= '0;
      k_q          <= '0;
      s_q          <= '0;
      c_q          <= '0;
      ofm_q        <= '0;
      plane_q      <= '0;
      row_step_q   <= '0;
      strip_step_q <= '0;
      strip_ptr_q  <= '0;
      row_ptr_q    <= '0;
      chan_q       <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      row_q        <= '0;
      col0_q       <= '0;
      tile_size_q  <= TILE_W'(SYSTOLIC_SIZE);
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      w_q          <= w_d;
      k_q          <= k_d;
      s_q          <= s_d;
      c_q          <= c_d;
      ofm_q        <= ofm_d;
      plane_q      <= plane_d;
      row_step_q   <= row_step_d;
      strip_step_q <= strip_step_d;
      strip_ptr_q  <= strip_ptr_d;
      row_ptr_q    <= row_ptr_d;
      chan_q       <= chan_d;
      line_q       <= line_d;
      addr_q       <= addr_d;
      row_q        <= row_d;
      col0_q       <= col0_d;
      tile_size_q  <= tile_size_d;
    end
  end

endmodule

// File: tb/tb_ifm_addr_gen.sv
// Self-checking bench for ifm_addr_gen: a loop-nest reference model of the
// layer walk is compared against the accepted address stream.
module tb_ifm_addr_gen;

  localparam int SYS = 16;
  localparam int AW  = 20;
  localparam int DW  = 10;
  localparam int CW  = 11;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [DW-1:0] cfg_ifm_size;
  logic [CW-1:0] cfg_channel;
  logic [1:0]    cfg_kernel;
  logic [1:0]    cfg_stride;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] ifm_addr;
  logic [4:0]    tile_size;
  logic          tile_last;
  logic          busy;
  logic          done;

  ifm_addr_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_base     (cfg_base),
    .cfg_ifm_size (cfg_ifm_size),
    .cfg_channel  (cfg_channel),
    .cfg_kernel   (cfg_kernel),
    .cfg_stride   (cfg_stride),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .ifm_addr     (ifm_addr),
    .tile_size    (tile_size),
    .tile_last    (tile_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int exp_addr[$];
  int exp_size[$];
  bit exp_last[$];
  int obs_addr[$];
  int obs_size[$];
  bit obs_last[$];

  int done_cnt;
  int valid_cycles;
  int stall_changes;
  bit timed_out;

  // Reference: the layer walk written as plain nested loops
  function automatic void build_model(input int w, input int k, input int s,
                                      input int c, input int base);
    int ofm;
    ofm = (w - k) / s + 1;
    exp_addr.delete();
    exp_size.delete();
    exp_last.delete();
    for (int col0 = 0; col0 < ofm; col0 += SYS)
      for (int row = 0; row < ofm; row++)
        for (int ch = 0; ch < c; ch++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              exp_addr.push_back((base + ch * w * w + (row * s + ky) * w + col0 * s + kx) & 32'hFFFFF);
              exp_size.push_back(((ofm - col0) < SYS) ? (ofm - col0) : SYS);
              exp_last.push_back((ch == c - 1) && (ky == k - 1) && (kx == k - 1));
            end
  endfunction

  function automatic int count_tiles();
    int n;
    n = 0;
    foreach (obs_last[i]) if (obs_last[i]) n++;
    return n;
  endfunction

  // Drives one layer and records every accepted beat; returns early after
  // abort_at accepted beats when abort_at >= 0.
  task automatic run_layer(input int w, input int k, input int s, input int c,
                           input int base, input int ready_pct, input int abort_at,
                           input bit poke);
    int cyc;
    int after_done;
    bit seen_done;
    bit stalled;
    int s_addr;
    int s_size;
    bit s_last;
    obs_addr.delete();
    obs_size.delete();
    obs_last.delete();
    done_cnt = 0;
    valid_cycles = 0;
    stall_changes = 0;
    timed_out = 0;
    s_addr = 0;
    s_size = 0;
    s_last = 0;
    @(negedge clk);
    cfg_base     = AW'(base);
    cfg_ifm_size = DW'(w);
    cfg_kernel   = 2'(k);
    cfg_stride   = 2'(s);
    cfg_channel  = CW'(c);
    start        = 1'b1;
    addr_ready   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    after_done = 0;
    seen_done = 0;
    stalled = 0;
    forever begin
      if (done) begin
        done_cnt++;
        seen_done = 1;
      end
      if (seen_done) begin
        if (after_done == 3) break;
        after_done++;
      end
      if (abort_at >= 0 && obs_addr.size() == abort_at) break;
      if (cyc >= 20000) begin
        timed_out = 1;
        break;
      end
      if (poke) begin
        start = (cyc == 7);
        if (cyc == 7) begin
          cfg_base     = 20'h00777;
          cfg_ifm_size = 10'd30;
          cfg_kernel   = 2'd1;
          cfg_stride   = 2'd1;
          cfg_channel  = 11'd5;
        end
      end
      addr_ready = (int'($urandom_range(99)) < ready_pct);
      if (addr_valid) begin
        valid_cycles++;
        if (stalled && (int'(ifm_addr) != s_addr || int'(tile_size) != s_size || tile_last != s_last))
          stall_changes++;
        if (addr_ready) begin
          obs_addr.push_back(int'(ifm_addr));
          obs_size.push_back(int'(tile_size));
          obs_last.push_back(tile_last);
          stalled = 0;
        end else begin
          stalled = 1;
          s_addr = int'(ifm_addr);
          s_size = int'(tile_size);
          s_last = tile_last;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    addr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    addr_ready = 1'b0;
    cfg_base = '0;
    cfg_ifm_size = '0;
    cfg_kernel = '0;
    cfg_stride = '0;
    cfg_channel = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", addr_valid); end
    checks++; if (ifm_addr !== 20'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", ifm_addr); end
    checks++; if (tile_size !== 5'd16) begin errors++; $display("FAIL reset_tile_size got %0d want 16", tile_size); end
    checks++; if (tile_last !== 1'b0) begin errors++; $display("FAIL reset_tile_last got %0b want 0", tile_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
  endtask

  // Four directed layers at full throughput, plus spot values for each
  task automatic test_directed();
    int cfgs[4][5] = '{'{34, 3, 1, 3, 0}, '{9, 3, 2, 1, 100}, '{20, 3, 1, 2, 0}, '{8, 1, 1, 4, 0}};
    int first10[10] = '{0, 1, 2, 34, 35, 36, 68, 69, 70, 1156};
    int k1_first[4] = '{0, 64, 128, 192};
    for (int t = 0; t < 4; t++) begin
      build_model(cfgs[t][0], cfgs[t][1], cfgs[t][2], cfgs[t][3], cfgs[t][4]);
      run_layer(cfgs[t][0], cfgs[t][1], cfgs[t][2], cfgs[t][3], cfgs[t][4], 100, -1, 0);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL directed%0d_timeout got %0b want 0", t, timed_out); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL directed%0d_done_pulses got %0d want 1", t, done_cnt); end
      checks++; if (valid_cycles !== exp_addr.size()) begin errors++; $display("FAIL directed%0d_no_bubbles valid_cycles got %0d want %0d", t, valid_cycles, exp_addr.size()); end
      checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL directed%0d_length got %0d want %0d", t, obs_addr.size(), exp_addr.size()); end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_size[i] !== exp_size[i] || obs_last[i] !== exp_last[i]) begin
          errors++;
          $display("FAIL directed%0d_beat%0d got addr=%0d size=%0d last=%0b want addr=%0d size=%0d last=%0b",
                   t, i, obs_addr[i], obs_size[i], obs_last[i], exp_addr[i], exp_size[i], exp_last[i]);
        end
      end
      case (t)
        0: begin
          for (int i = 0; i < 10; i++) begin
            checks++; if (obs_addr[i] !== first10[i]) begin errors++; $display("FAIL c1_first_addr%0d got %0d want %0d", i, obs_addr[i], first10[i]); end
          end
          checks++; if (obs_addr[27] !== 34) begin errors++; $display("FAIL c1_tile1_start got %0d want 34", obs_addr[27]); end
          checks++; if (obs_addr[32 * 27] !== 16) begin errors++; $display("FAIL c1_tile32_start got %0d want 16", obs_addr[32 * 27]); end
          checks++; if (count_tiles() !== 64) begin errors++; $display("FAIL c1_tiles got %0d want 64", count_tiles()); end
        end
        1: begin
          checks++; if (obs_addr[9] !== 118) begin errors++; $display("FAIL c2_tile1_start got %0d want 118", obs_addr[9]); end
          checks++; if (obs_addr[35] !== 174) begin errors++; $display("FAIL c2_tile3_end got %0d want 174", obs_addr[35]); end
          checks++; if (obs_size[0] !== 4) begin errors++; $display("FAIL c2_tile_size got %0d want 4", obs_size[0]); end
        end
        2: begin
          checks++; if (obs_size[0] !== 16) begin errors++; $display("FAIL c3_strip0_size got %0d want 16", obs_size[0]); end
          checks++; if (obs_addr[324] !== 16) begin errors++; $display("FAIL c3_strip1_start got %0d want 16", obs_addr[324]); end
          checks++; if (obs_size[324] !== 2) begin errors++; $display("FAIL c3_strip1_size got %0d want 2", obs_size[324]); end
          checks++; if (count_tiles() !== 36) begin errors++; $display("FAIL c3_tiles got %0d want 36", count_tiles()); end
        end
        default: begin
          for (int i = 0; i < 4; i++) begin
            checks++; if (obs_addr[i] !== k1_first[i]) begin errors++; $display("FAIL c4_addr%0d got %0d want %0d", i, obs_addr[i], k1_first[i]); end
          end
          checks++; if (obs_last[2] !== 1'b0 || obs_last[3] !== 1'b1) begin errors++; $display("FAIL c4_tile_last got %0b%0b want 01", obs_last[2], obs_last[3]); end
          checks++; if (count_tiles() !== 8) begin errors++; $display("FAIL c4_tiles got %0d want 8", count_tiles()); end
          checks++; if (obs_size[0] !== 8) begin errors++; $display("FAIL c4_tile_size got %0d want 8", obs_size[0]); end
        end
      endcase
    end
  endtask

  // Random backpressure on the large layer: same sequence, frozen outputs while stalled
  task automatic test_stall();
    build_model(34, 3, 1, 3, 0);
    run_layer(34, 3, 1, 3, 0, 50, -1, 0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_timeout got %0b want 0", timed_out); end
    checks++; if (stall_changes !== 0) begin errors++; $display("FAIL stall_stability changes got %0d want 0", stall_changes); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done_pulses got %0d want 1", done_cnt); end
    checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL stall_length got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_size[i] !== exp_size[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL stall_beat%0d got addr=%0d size=%0d last=%0b want addr=%0d size=%0d last=%0b",
                 i, obs_addr[i], obs_size[i], obs_last[i], exp_addr[i], exp_size[i], exp_last[i]);
      end
    end
  endtask

  // A start pulse with different cfg while running must leave the stream untouched
  task automatic test_start_while_busy();
    build_model(9, 3, 2, 1, 100);
    run_layer(9, 3, 2, 1, 100, 100, -1, 1);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done_pulses got %0d want 1", done_cnt); end
    checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL busy_start_length got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_size[i] !== exp_size[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL busy_start_beat%0d got addr=%0d size=%0d last=%0b want addr=%0d size=%0d last=%0b",
                 i, obs_addr[i], obs_size[i], obs_last[i], exp_addr[i], exp_size[i], exp_last[i]);
      end
    end
  endtask

  // Asynchronous reset in the middle of tile 5, then a clean restart
  task automatic test_reset_mid();
    run_layer(34, 3, 1, 3, 0, 100, 4 * 27 + 5, 0);
    checks++; if (addr_valid !== 1'b1 || ifm_addr === 20'd0) begin errors++; $display("FAIL midreset_precondition got valid=%0b addr=%0d want valid=1 addr nonzero", addr_valid, ifm_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (addr_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %0b want 0", addr_valid); end
    checks++; if (ifm_addr !== 20'd0) begin errors++; $display("FAIL midreset_addr got %0d want 0", ifm_addr); end
    checks++; if (tile_size !== 5'd16) begin errors++; $display("FAIL midreset_tile_size got %0d want 16", tile_size); end
    checks++; if (tile_last !== 1'b0) begin errors++; $display("FAIL midreset_tile_last got %0b want 0", tile_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_no_done cycle %0d got %0b want 0", i, done); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_after_release got done=%0b busy=%0b want 0 0", done, busy); end
    build_model(34, 3, 1, 3, 0);
    run_layer(34, 3, 1, 3, 0, 100, -1, 0);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt); end
    checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL restart_length got %0d want %0d", obs_addr.size(), exp_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_size[i] !== exp_size[i] || obs_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL restart_beat%0d got addr=%0d size=%0d last=%0b want addr=%0d size=%0d last=%0b",
                 i, obs_addr[i], obs_size[i], obs_last[i], exp_addr[i], exp_size[i], exp_last[i]);
      end
    end
  endtask

  // Random legal small layers with random backpressure and random base (incl. wrap)
  task automatic test_random();
    int w, k, s, c, base;
    for (int t = 0; t < 6; t++) begin
      k = ($urandom_range(1) == 1) ? 3 : 1;
      s = int'($urandom_range(2, 1));
      w = int'($urandom_range(40, 3));
      c = int'($urandom_range(3, 1));
      base = int'($urandom_range(20'hFFFFF));
      build_model(w, k, s, c, base);
      run_layer(w, k, s, c, base, 70, -1, 0);
      checks++; if (done_cnt !== 1 || timed_out !== 1'b0) begin errors++; $display("FAIL rand%0d_end got done=%0d timeout=%0b want 1 0", t, done_cnt, timed_out); end
      checks++; if (stall_changes !== 0) begin errors++; $display("FAIL rand%0d_stability got %0d want 0", t, stall_changes); end
      checks++; if (obs_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL rand%0d_length got %0d want %0d (w=%0d k=%0d s=%0d c=%0d)", t, obs_addr.size(), exp_addr.size(), w, k, s, c); end
      for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
        checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_size[i] !== exp_size[i] || obs_last[i] !== exp_last[i]) begin
          errors++;
          $display("FAIL rand%0d_beat%0d got addr=%0d size=%0d last=%0b want addr=%0d size=%0d last=%0b",
                   t, i, obs_addr[i], obs_size[i], obs_last[i], exp_addr[i], exp_size[i], exp_last[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
